// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: default bus widths, FSM state
// encoding and grant encoding.
package mem_pkg;

   localparam int MEM_ADDR_W = 4;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between instruction fetch and data access.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
   import mem_pkg::*;
(
   input  logic   req_if,
   input  logic   req_d,
   input  grant_e last_grant,
   output logic   valid,
   output grant_e grant
);

   always_comb begin
      valid = req_if | req_d;
      if (req_if && req_d) begin
         grant = (last_grant == GNT_D) ? GNT_IF : GNT_D;
      end else if (req_if) begin
         grant = GNT_IF;
      end else begin
         grant = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and data access:
// one accepted request at a time, strobes held for ACCESS_CYCLES, valid pulse after.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W        = MEM_ADDR_W,
   parameter int DATA_W        = MEM_DATA_W,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam int              CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   grant_e            last_grant_q, last_grant_d;
   grant_e            gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              if_valid_q, if_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic   pick_valid;
   grant_e pick;

   rr_arbiter2 u_rr (
      .req_if     (if_req),
      .req_d      (d_req),
      .last_grant (last_grant_q),
      .valid      (pick_valid),
      .grant      (pick)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_d         = 1'b0;
      wr_d         = 1'b0;
      if_valid_d   = 1'b0;
      d_valid_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_ack       = 1'b0;
      d_ack        = 1'b0;

      case (state_q)
         IDLE: begin
            // A request seen while reset is asserted is never accepted.
            if (pick_valid && !rst) begin
               if_ack       = (pick == GNT_IF);
               d_ack        = (pick == GNT_D);
               gnt_d        = pick;
               last_grant_d = pick;
               if (pick == GNT_D) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr;
                  wdata_d = '0;
               end
               rd_d    = !we_d;
               wr_d    = we_d;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  if (gnt_q == GNT_IF) if_rdata_d = mem_data_out;
                  else                 d_rdata_d  = mem_data_out;
               end
               if_valid_d = (gnt_q == GNT_IF);
               d_valid_d  = (gnt_q == GNT_D);
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               rd_d  = !we_q;
               wr_d  = we_q;
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= GNT_D;
         gnt_q        <= GNT_IF;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         if_valid_q   <= if_valid_d;
         d_valid_q    <= d_valid_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign mem_address = addr_q;
   assign mem_data_in = wdata_q;
   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign if_valid    = if_valid_q;
   assign d_valid     = d_valid_q;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (ACCESS_CYCLES 1 and 3), each with a memory
// and a cycle-level transaction model, plus directed vectors with literal expectations.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic       rst          [2];
   logic       if_req       [2];
   logic [3:0] if_addr      [2];
   logic       if_ack       [2];
   logic       if_valid     [2];
   logic [7:0] if_rdata     [2];
   logic       d_req        [2];
   logic       d_we         [2];
   logic [3:0] d_addr       [2];
   logic [7:0] d_wdata      [2];
   logic       d_ack        [2];
   logic       d_valid      [2];
   logic [7:0] d_rdata      [2];
   logic [3:0] mem_address  [2];
   logic       mem_read     [2];
   logic       mem_write    [2];
   logic [7:0] mem_data_in  [2];
   logic [7:0] mem_data_out [2];

   function automatic logic [7:0] init_val(input int i);
      if (i == 0)  return 8'h4C;
      if (i == 10) return 8'h02;
      return 8'h30 + 8'(i);
   endfunction

   task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h (t=%0t)", name, k, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int AC = (g == 0) ? 1 : 3;

      logic [7:0] bmem [16];
      bit b_init = 1'b0;

      mem_arbiter #(.ADDR_W(4), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
         .clk          (clk),
         .rst          (rst[g]),
         .if_req       (if_req[g]),
         .if_addr      (if_addr[g]),
         .if_ack       (if_ack[g]),
         .if_valid     (if_valid[g]),
         .if_rdata     (if_rdata[g]),
         .d_req        (d_req[g]),
         .d_we         (d_we[g]),
         .d_addr       (d_addr[g]),
         .d_wdata      (d_wdata[g]),
         .d_ack        (d_ack[g]),
         .d_valid      (d_valid[g]),
         .d_rdata      (d_rdata[g]),
         .mem_address  (mem_address[g]),
         .mem_read     (mem_read[g]),
         .mem_write    (mem_write[g]),
         .mem_data_in  (mem_data_in[g]),
         .mem_data_out (mem_data_out[g])
      );

      assign mem_data_out[g] = bmem[mem_address[g]];

      always @(posedge clk) begin
         if (!b_init) begin
            for (int i = 0; i < 16; i++) bmem[i] <= init_val(i);
            b_init <= 1'b1;
         end else if (mem_write[g]) begin
            bmem[mem_address[g]] <= mem_data_in[g];
         end
      end

      // Transaction model: a request accepted in cycle s strobes in s+1..s+AC,
      // pulses valid in s+AC+1 and frees the memory from s+AC+2 on.
      logic [7:0] mm [16];
      bit         m_init = 1'b0;
      bit         have   = 1'b0;
      bit         who    = 1'b0;    // 0 = IF, 1 = D
      bit         m_we   = 1'b0;
      bit         last   = 1'b1;    // last grant, D after reset
      logic [3:0] m_addr  = '0;
      logic [7:0] m_wdata = '0;
      logic [7:0] rd_if   = '0;
      logic [7:0] rd_d    = '0;
      int         c = 0;
      int         start = 0;

      always @(negedge clk) begin
         bit idle, strobe, pend, win;
         if (!m_init) begin
            for (int i = 0; i < 16; i++) mm[i] = init_val(i);
            m_init = 1'b1;
         end
         idle   = !have || (c >= start + AC + 2);
         strobe = have && (c >= start + 1) && (c <= start + AC);
         pend   = !rst[g] && idle && (if_req[g] || d_req[g]);
         win    = (if_req[g] && d_req[g]) ? !last : d_req[g];

         check(g, "if_ack",    32'(if_ack[g]),    32'(pend && !win));
         check(g, "d_ack",     32'(d_ack[g]),     32'(pend && win));
         check(g, "mem_read",  32'(mem_read[g]),  32'(strobe && !m_we));
         check(g, "mem_write", 32'(mem_write[g]), 32'(strobe && m_we));
         check(g, "if_valid",  32'(if_valid[g]),  32'(have && c == start + AC + 1 && !who));
         check(g, "d_valid",   32'(d_valid[g]),   32'(have && c == start + AC + 1 && who));
         check(g, "if_rdata",  32'(if_rdata[g]),  32'(rd_if));
         check(g, "d_rdata",   32'(d_rdata[g]),   32'(rd_d));
         if (strobe) check(g, "mem_address", 32'(mem_address[g]), 32'(m_addr));
         if (strobe && m_we) check(g, "mem_data_in", 32'(mem_data_in[g]), 32'(m_wdata));

         // The memory still takes a write on the edge that resets the arbiter.
         if (strobe && m_we) mm[m_addr] = m_wdata;
         if (rst[g]) begin
            have  = 1'b0;
            last  = 1'b1;
            rd_if = '0;
            rd_d  = '0;
         end else begin
            if (have && !m_we && c == start + AC) begin
               if (who) rd_d = mm[m_addr];
               else     rd_if = mm[m_addr];
            end
            if (pend) begin
               have    = 1'b1;
               start   = c;
               who     = win;
               m_we    = win ? d_we[g] : 1'b0;
               m_addr  = win ? d_addr[g] : if_addr[g];
               m_wdata = win ? d_wdata[g] : 8'h00;
               last    = win;
            end
         end
         c++;
      end
   end

   // One transaction on instance k; checks ack, latency, strobe length and returned data.
   task automatic xact(input int k, input bit is_d, input bit we, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rd, input int exp_lat);
      int  t0, n, strobes;
      bit  got;
      @(posedge clk); #1;
      if (is_d) begin
         d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
      end else begin
         if_addr[k] = a; if_req[k] = 1'b1;
      end
      got = 1'b0;
      t0  = 0;
      for (n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (is_d ? d_ack[k] : if_ack[k]) begin
            got = 1'b1;
            t0  = cyc;
         end
      end
      check(k, "ack_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      if_req[k] = 1'b0;
      d_req[k]  = 1'b0;
      got     = 1'b0;
      strobes = 0;
      for (n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (is_d ? d_valid[k] : if_valid[k]) got = 1'b1;
         else if (mem_read[k] || mem_write[k]) strobes++;
      end
      check(k, "valid_seen", 32'(got), 32'd1);
      check(k, "ack_to_valid", 32'(cyc - t0), 32'(exp_lat));
      check(k, "strobe_cycles", 32'(strobes), 32'(exp_lat - 1));
      check(k, "rdata", 32'(is_d ? d_rdata[k] : if_rdata[k]), 32'(exp_rd));
   endtask

   task automatic do_reset(input int k, input int n);
      @(posedge clk); #1;
      rst[k] = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst[k] = 1'b0;
   endtask

   task automatic tie(input int k);
      @(posedge clk); #1;
      if_addr[k] = 4'h1; d_we[k] = 1'b0; d_addr[k] = 4'h2;
      if_req[k] = 1'b1; d_req[k] = 1'b1;
      @(negedge clk);
      check(k, "tie_if_ack", 32'(if_ack[k]), 32'd1);
      check(k, "tie_d_ack", 32'(d_ack[k]), 32'd0);
      @(posedge clk); #1;
      if_req[k] = 1'b0; d_req[k] = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  ack_cyc [4];
      bit  ack_who [4];
      int  n_ack;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst[0] = 1'b0; rst[1] = 1'b0;

      repeat (5) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check(k, "idle_strobes", 32'({mem_read[k], mem_write[k]}), 32'd0);
            check(k, "idle_acks_valids", 32'({if_ack[k], d_ack[k], if_valid[k], d_valid[k]}), 32'd0);
            check(k, "idle_rdata", 32'({if_rdata[k], d_rdata[k]}), 32'd0);
            check(k, "idle_address", 32'(mem_address[k]), 32'd0);
         end
      end

      xact(0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h4C, 2);   // fetch 0x0
      xact(0, 1'b1, 1'b1, 4'hB, 8'hE0, 8'h00, 2);   // write: d_rdata stays 0
      xact(0, 1'b1, 1'b0, 4'hB, 8'h00, 8'hE0, 2);   // read back
      xact(1, 1'b0, 1'b0, 4'hA, 8'h00, 8'h02, 4);   // long access window

      // Both requesters held from reset: IF, D, IF, D, three cycles apart.
      do_reset(0, 2);
      if_addr[0] = 4'h1; d_we[0] = 1'b0; d_addr[0] = 4'h2;
      if_req[0] = 1'b1; d_req[0] = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if ((if_ack[0] || d_ack[0]) && n_ack < 4) begin
            ack_cyc[n_ack] = cyc;
            ack_who[n_ack] = d_ack[0];
            n_ack++;
         end
      end
      @(posedge clk); #1;
      if_req[0] = 1'b0; d_req[0] = 1'b0;
      repeat (4) @(negedge clk);
      check(0, "rr_ack_count", 32'(n_ack), 32'd4);
      if (n_ack == 4) begin
         check(0, "rr_order", 32'({ack_who[0], ack_who[1], ack_who[2], ack_who[3]}), 32'b0101);
         for (int i = 1; i < 4; i++) check(0, "rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end

      // After an IF grant, reset must hand the next tie back to IF.
      xact(0, 1'b0, 1'b0, 4'h3, 8'h00, 8'h33, 2);
      do_reset(0, 1);
      tie(0);

      // Reset in the 2nd access cycle of a write on the ACCESS_CYCLES=3 instance.
      @(posedge clk); #1;
      d_we[1] = 1'b1; d_addr[1] = 4'h5; d_wdata[1] = 8'h77; d_req[1] = 1'b1;
      begin
         bit got = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (d_ack[1]) got = 1'b1;
         end
         check(1, "abort_ack_seen", 32'(got), 32'd1);
      end
      @(posedge clk); #1 d_req[1] = 1'b0;
      @(posedge clk); #1 rst[1] = 1'b1;
      @(negedge clk);
      check(1, "abort_write_before", 32'(mem_write[1]), 32'd1);
      @(posedge clk); #1 rst[1] = 1'b0;
      @(negedge clk);
      check(1, "abort_strobes", 32'({mem_read[1], mem_write[1]}), 32'd0);
      repeat (4) begin
         @(negedge clk);
         check(1, "abort_no_valid", 32'(d_valid[1]), 32'd0);
      end
      tie(1);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-ported 16x8 memory between two requesters: instruction fetch (IF, read-only) and data access (D, read/write).
- Accepts one request at a time via a req/ack handshake and holds the memory strobes for a fixed access window.
- Captures read data and returns it to the winning requester with a one-cycle valid pulse.
- Sits between the CPU control unit and the memory; it is the only driver of the memory's address, read, write and data_in.

Parameters:
- ADDR_W, 4, memory address width
- DATA_W, 8, memory data width
- ACCESS_CYCLES, 1, cycles the strobes are held per access (range 1..15)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched byte
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: read data valid, or write complete
- d_rdata  out  DATA_W  read byte; unchanged on writes
- mem_address  out  ADDR_W  to memory
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_data_in  out  DATA_W  to memory
- mem_data_out  in  DATA_W  from memory; combinational read

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, last_grant = D (so IF wins the first tie).
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending:
  - Pick the winner; pulse its ack in this cycle.
  - Latch the winner's address, we and wdata into internal registers; update last_grant.
  - Load the counter with ACCESS_CYCLES-1 and go to ACCESS.
- Arbitration:
  - Only one request pending: it wins.
  - Both pending: round-robin, so the requester not in last_grant wins.
  - Fairness: neither requester waits more than one transaction while its req is held.
- ACCESS:
  - mem_address, mem_data_in, mem_read/mem_write are registered and driven from the latched values for exactly ACCESS_CYCLES cycles.
  - mem_read = !we, mem_write = we. The two strobes are never high together.
  - Counter decrements each cycle.
  - At counter == 0, sample mem_data_out into the winner's rdata register (reads only) and go to DONE.
- DONE:
  - All strobes 0; pulse the winner's valid for one cycle; return to IDLE.
  - A new request cannot be accepted in DONE.
- Latency and throughput:
  - ack to valid = ACCESS_CYCLES+1 cycles.
  - One transaction per ACCESS_CYCLES+2 cycles.
- The loser's req remains pending and is served next, with no ack until then.
- A req dropped before its ack is ignored. Inputs are not sampled after ack.
- rdata registers hold their value until the next read to the same port.
- Reset mid-transaction: the transaction is aborted, strobes drop on that edge, no valid is issued, and last_grant returns to D.
- Address is ADDR_W bits; no range checking (all 16 locations legal).

Decomposition:
- Shared package mem_pkg: ADDR_W/DATA_W defaults, state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), grant encoding (GNT_IF=1'b0, GNT_D=1'b1).
- Optional sub-module rr_arbiter2: combinational two-way round-robin pick from req_if, req_d and last_grant. The FSM and counter stay in mem_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; mem_read and mem_write never asserted.
- Bench memory model loc 0x0 = 0x4C; if_req, if_addr=0x0 (ACCESS_CYCLES=1) -> if_ack in cycle 0; mem_read=1 with mem_address=0x0 in cycle 1; if_valid with if_rdata=0x4C in cycle 2.
- D write then read: d_req, d_we=1, d_addr=0xB, d_wdata=0xE0 -> mem_write one cycle, d_valid pulse, d_rdata unchanged. Then d_we=0 to 0xB -> d_rdata=0xE0.
- if_req and d_req both asserted from reset, held continuously -> grant order IF, D, IF, D. Every ack is one cycle, transactions 3 cycles apart, strobes never overlap.
- ACCESS_CYCLES=3, fetch of 0xA (= 0x02) -> mem_read high exactly 3 cycles; if_valid 4 cycles after if_ack with 0x02.
- rst asserted in the 2nd ACCESS cycle of a D write -> strobes 0 on the next edge, no d_valid. A simultaneous IF/D request after reset -> IF granted first.
